// File: rtl/alu_pkg.sv
// Shared ALU control encodings and the scheduler FSM state type.
package alu_pkg;
  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_OR     = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_SLL    = 4'b0011;
  localparam logic [3:0] ALU_SLT    = 4'b0100;
  localparam logic [3:0] ALU_SLTU   = 4'b0101;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_XOR    = 4'b0111;
  localparam logic [3:0] ALU_ADDI12 = 4'b1000;
  localparam logic [3:0] ALU_MUL    = 4'b1001;
  localparam logic [3:0] ALU_EQ     = 4'b1110;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, ties go to the requester that was not served last.
module rr_arbiter2 (
  input  logic       en,
  input  logic [1:0] req_valid,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req_valid == 2'b11) grant = last ? 2'b01 : 2'b10;
      else                    grant = req_valid;
    end
  end
endmodule

// File: rtl/alu_scheduler.sv
// Shares one single-cycle ALU between two requesters; MUL holds the ALU for MulCycles cycles.
module alu_scheduler
  import alu_pkg::*;
#(
  parameter int Width     = 32,
  parameter int MulCycles = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req_control0,
  input  logic [3:0]       req_control1,
  input  logic [Width-1:0] req_op1_0,
  input  logic [Width-1:0] req_op2_0,
  input  logic [Width-1:0] req_op1_1,
  input  logic [Width-1:0] req_op2_1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [Width-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [3:0]       alu_control,
  output logic [Width-1:0] alu_operand1,
  output logic [Width-1:0] alu_operand2,
  input  logic [Width-1:0] alu_result,
  input  logic             alu_zero
);
  state_t           state, state_nx;
  logic             last, owner;
  logic [3:0]       cnt;
  logic [3:0]       ctl_q;
  logic [Width-1:0] op1_q, op2_q, res_q;
  logic             zero_q;
  logic [3:0]       sel_ctl;
  logic [Width-1:0] sel_op1, sel_op2;

  // rst_n gate keeps req_ready low for the whole reset window
  rr_arbiter2 u_arb (
    .en       (state == IDLE && rst_n),
    .req_valid(req_valid),
    .last     (last),
    .grant    (req_ready)
  );

  assign sel_ctl = req_ready[1] ? req_control1 : req_control0;
  assign sel_op1 = req_ready[1] ? req_op1_1    : req_op1_0;
  assign sel_op2 = req_ready[1] ? req_op2_1    : req_op2_0;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|req_ready) state_nx = EXEC;
      EXEC:    if (cnt == 4'd0) state_nx = RESP;
      RESP:    if (rsp_ready[owner]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      last   <= 1'b1;
      owner  <= 1'b0;
      cnt    <= 4'd0;
      ctl_q  <= 4'd0;
      op1_q  <= '0;
      op2_q  <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (|req_ready) begin
          owner <= req_ready[1];
          ctl_q <= sel_ctl;
          op1_q <= sel_op1;
          op2_q <= sel_op2;
          cnt   <= (sel_ctl == ALU_MUL) ? 4'(MulCycles - 1) : 4'd0;
        end
        EXEC: if (cnt == 4'd0) begin
          res_q  <= alu_result;
          zero_q <= alu_zero;
          // drop the control code once sampled so MUL is presented only for its hold window
          ctl_q  <= 4'd0;
        end else begin
          cnt <= cnt - 4'd1;
        end
        RESP: if (rsp_ready[owner]) last <= owner;
        default: ;
      endcase
    end
  end

  assign rsp_valid    = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result   = res_q;
  assign rsp_zero     = zero_q;
  assign alu_control  = ctl_q;
  assign alu_operand1 = op1_q;
  assign alu_operand2 = op2_q;
endmodule
